// File: rtl/mux_nx2_blanking.sv
// Dual-output channel mux over a shared bank of per-channel hold registers.
// Each output zeroes itself for a fixed span when its source changes.

module mux_nx2_blanking_lane #(
  parameter int WIDTH        = 14,
  parameter int N_IN         = 8,
  parameter int SEL_W        = 3,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_IN-1:0][WIDTH-1:0]  hold,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            out,
  output logic                        busy
);
  typedef enum logic {RUN = 1'b0, BLANK = 1'b1} state_t;

  typedef struct packed {
    state_t           st;
    logic             tail;
    logic [SEL_W-1:0] act;
    logic [SEL_W-1:0] pend;
    logic [15:0]      cnt;
  } lane_t;

  localparam logic [15:0] RELOAD = 16'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  lane_t q;
  logic  sel_ok;

  assign sel_ok = (32'(sel) < 32'(N_IN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q   <= '0;
      out <= '0;
    end else begin
      q.tail <= 1'b0;
      case (q.st)
        RUN: begin
          if (sel_ok && sel != q.act) begin
            if (BLANK_CYCLES == 0) begin
              q.act <= sel;
              out   <= hold[sel];
            end else begin
              q.st   <= BLANK;
              q.pend <= sel;
              q.cnt  <= RELOAD;
              out    <= '0;
            end
          end else begin
            out <= hold[q.act];
          end
        end
        BLANK: begin
          out <= '0;
          if (sel_ok && sel != q.pend) begin
            q.pend <= sel;
            q.cnt  <= RELOAD;
          end else if (q.cnt == '0) begin
            // last zero cycle is spent in RUN; tail keeps busy aligned with it
            q.st   <= RUN;
            q.act  <= q.pend;
            q.tail <= 1'b1;
          end else begin
            q.cnt <= q.cnt - 16'd1;
          end
        end
        default: q.st <= RUN;
      endcase
    end
  end

  assign busy = (q.st == BLANK) | q.tail;
endmodule

module mux_nx2_blanking #(
  parameter int WIDTH        = 14,
  parameter int N_IN         = 8,
  parameter int SEL_W        = 3,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_IN*WIDTH-1:0]   in_i,
  input  logic [N_IN-1:0]         valid_i,
  input  logic [SEL_W-1:0]        select0_i,
  input  logic [SEL_W-1:0]        select1_i,
  output logic [WIDTH-1:0]        out0_o,
  output logic [WIDTH-1:0]        out1_o,
  output logic [31:0]             dac_o,
  output logic [1:0]              busy_o
);
  logic [N_IN-1:0][WIDTH-1:0] hold;
  logic [1:0][SEL_W-1:0]      sel;
  logic [1:0][WIDTH-1:0]      out_q;

  assign sel = {select1_i, select0_i};

  for (genvar k = 0; k < N_IN; k++) begin : g_hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         hold[k] <= '0;
      else if (valid_i[k]) hold[k] <= in_i[k*WIDTH +: WIDTH];
    end
  end

  for (genvar j = 0; j < 2; j++) begin : g_lane
    mux_nx2_blanking_lane #(
      .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .BLANK_CYCLES(BLANK_CYCLES)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .hold   (hold),
      .sel    (sel[j]),
      .out    (out_q[j]),
      .busy   (busy_o[j])
    );
  end

  assign out0_o = out_q[0];
  assign out1_o = out_q[1];
  assign dac_o  = {16'($signed(out_q[1])), 16'($signed(out_q[0]))};
endmodule

// File: tb/tb_mux_nx2_blanking.sv
// Bench: three builds (default, short blank, 6 channels with no blank) driven
// in parallel and compared every cycle against a zero-span-counting model.

module tb_mux_nx2_blanking;
  localparam int W = 14;
  localparam int NN  [3] = '{8, 8, 6};
  localparam int BCY [3] = '{16, 4, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [8*W-1:0]       in_bus;
  logic [7:0]           vld;
  logic [2:0]           sel0, sel1;
  logic [2:0][W-1:0]    o0, o1;
  logic [2:0][1:0]      bsy;
  logic [2:0][31:0]     dac;

  mux_nx2_blanking u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_bus), .valid_i(vld),
    .select0_i(sel0), .select1_i(sel1),
    .out0_o(o0[0]), .out1_o(o1[0]), .dac_o(dac[0]), .busy_o(bsy[0]));

  mux_nx2_blanking #(.BLANK_CYCLES(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_bus), .valid_i(vld),
    .select0_i(sel0), .select1_i(sel1),
    .out0_o(o0[1]), .out1_o(o1[1]), .dac_o(dac[1]), .busy_o(bsy[1]));

  mux_nx2_blanking #(.N_IN(6), .BLANK_CYCLES(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_bus[6*W-1:0]), .valid_i(vld[5:0]),
    .select0_i(sel0), .select1_i(sel1),
    .out0_o(o0[2]), .out1_o(o1[2]), .dac_o(dac[2]), .busy_o(bsy[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: per output, the source in use, the requested source and how many
  // zero cycles remain; the first zero of a span is the edge that sees the change.
  int           cur [3][2];
  int           pend[3][2];
  int           zl  [3][2];
  logic [W-1:0] eo  [3][2];
  logic         eb  [3][2];
  logic [W-1:0] mh  [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mh[k] = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 2; j++) begin
          cur[i][j] = 0; pend[i][j] = 0; zl[i][j] = 0; eo[i][j] = '0; eb[i][j] = 1'b0;
        end
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 2; j++) begin
          int  s;
          bit  ok;
          s  = (j == 1) ? int'(sel1) : int'(sel0);
          ok = s < NN[i];
          if (zl[i][j] == 0) begin
            if (ok && s != cur[i][j]) begin
              if (BCY[i] == 0) begin
                cur[i][j] = s; eo[i][j] = mh[s]; eb[i][j] = 1'b0;
              end else begin
                pend[i][j] = s; zl[i][j] = BCY[i]; eo[i][j] = '0; eb[i][j] = 1'b1;
              end
            end else begin
              eo[i][j] = mh[cur[i][j]]; eb[i][j] = 1'b0;
            end
          end else begin
            if (ok && s != pend[i][j]) begin
              pend[i][j] = s; zl[i][j] = BCY[i];
            end else begin
              zl[i][j] = zl[i][j] - 1;
              if (zl[i][j] == 0) cur[i][j] = pend[i][j];
            end
            eo[i][j] = '0; eb[i][j] = 1'b1;
          end
        end
      for (int k = 0; k < 8; k++) if (vld[k]) mh[k] = in_bus[k*W +: W];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk("out0", 32'(o0[i]), 32'(eo[i][0]));
        chk("out1", 32'(o1[i]), 32'(eo[i][1]));
        chk("busy", 32'(bsy[i]), 32'({eb[i][1], eb[i][0]}));
        chk("dac", dac[i], {16'($signed(eo[i][1])), 16'($signed(eo[i][0]))});
      end
    end
  end

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_bus[k*W +: W] = v;
  endtask

  int z, b, d;

  initial begin
    rst_n = 1'b0; in_bus = '0; vld = '0; sel0 = '0; sel1 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out0", 32'(o0[i]), 32'd0);
      chk("rst_out1", 32'(o1[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_dac", dac[i], 32'd0);
    end

    // channel 0 = 100 continuously, other channels loaded once
    rst_n = 1'b1;
    set_ch(0, 14'd100); set_ch(1, 14'd111); set_ch(3, 14'd300);
    set_ch(4, 14'd400); set_ch(5, 14'd500);
    vld = 8'b0011_1011;
    @(negedge clk); vld = 8'h01;
    @(negedge clk);
    chk("lat_out0", 32'(o0[0]), 32'd100);
    chk("lat_out1", 32'(o1[0]), 32'd100);
    chk("lat_dac", dac[0], 32'h0064_0064);

    // ch2 = -5 for one edge, then changes with valid low
    set_ch(2, 14'h3FFB); vld = 8'h05;
    @(negedge clk); vld = 8'h01; set_ch(2, 14'd77); sel1 = 3'd2;
    @(negedge clk);
    chk("hold_neg", 32'(o1[2]), 32'h3FFB);
    chk("hold_dac", 32'(dac[2][31:16]), 32'hFFFB);
    @(negedge clk);
    chk("hold_keep", 32'(o1[2]), 32'h3FFB);
    repeat (20) @(negedge clk);

    // clean change on the 16-cycle build
    sel0 = 3'd3; z = 0; b = 0;
    repeat (25) begin
      @(negedge clk);
      if (o0[0] == '0) z++;
      if (bsy[0][0]) b++;
    end
    chk("blank16_zeros", 32'(z), 32'd17);
    chk("blank16_busy", 32'(b), 32'd17);
    chk("blank16_new", 32'(o0[0]), 32'd300);
    chk("blank16_out1", 32'(o1[0]), 32'h3FFB);

    // restart on the 4-cycle build
    sel0 = 3'd4; z = 0;
    repeat (2) begin @(negedge clk); if (o0[1] == '0) z++; end
    sel0 = 3'd5;
    repeat (13) begin @(negedge clk); if (o0[1] == '0) z++; end
    chk("restart_zeros", 32'(z), 32'd7);
    chk("restart_new", 32'(o0[1]), 32'd500);
    repeat (6) @(negedge clk);

    // out-of-range select and zero-blank switch on the 6-channel build
    sel1 = 3'd7; sel0 = 3'd1;
    @(negedge clk);
    chk("noblank_switch", 32'(o0[2]), 32'd111);
    b = 0; d = 0;
    repeat (5) begin
      @(negedge clk);
      if (bsy[2][1]) b++;
      if (o1[2] != 14'h3FFB) d++;
    end
    chk("ign_busy", 32'(b), 32'd0);
    chk("ign_keep", 32'(d), 32'd0);

    // reset in the middle of a blank
    sel0 = 3'd6;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out0", 32'(o0[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_dac", dac[0], 32'd0);
    @(negedge clk); rst_n = 1'b1; sel0 = 3'd0; sel1 = 3'd0;
    repeat (2) @(negedge clk);
    chk("post_rst_out0", 32'(o0[0]), 32'd100);
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
